sobel_hls_deadlock_reporter: RTL and testbench
==============================================

// Module: sobel_hls_deadlock_reporter
// PURPOSE
//  Consumer end of the sobel deadlock-monitor chain. Takes the registered `block` output of the
//  top-level monitor plus the raw AXIS/instance status vectors and qualifies persistence.
//  Declares a deadlock only after THRESHOLD consecutive blocked cycles.
//  Captures a snapshot of the stall signature and delivers it once over a valid/ready report port.
//  Also maintains a sticky flag and a saturating event count for the host/debug path.
// PARAMETERS
//  THRESHOLD  1024  consecutive block cycles required to declare deadlock (>=1; 0 is illegal)
//  CNT_W      16    stall-cycle counter width (2^CNT_W-1 >= THRESHOLD)
//  EVT_W      8     deadlock event counter width
//  NUM_AXIS   3     width of axis_block_sigs
//  NUM_INST   3     width of inst_idle_sigs
// PORTS
//  clock            in   1         sole clock, rising edge
//  reset            in   1         synchronous, active-high
//  enable           in   1         1 = detection armed
//  block            in   1         from top-level deadlock monitor (already registered)
//  axis_block_sigs  in   NUM_AXIS  per-channel AXIS blocked status
//  inst_idle_sigs   in   NUM_INST  per-instance idle status
//  clear            in   1         clears deadlock_flag
//  rpt_valid        out  1         report available
//  rpt_ready        in   1         report consumer accepts
//  rpt_axis_mask    out  NUM_AXIS  axis_block_sigs captured at detection
//  rpt_idle_mask    out  NUM_INST  inst_idle_sigs captured at detection
//  stall_cycles     out  CNT_W     live consecutive-block count, saturating
//  deadlock_flag    out  1         sticky; set on detection
//  deadlock_events  out  EVT_W     detections since reset, saturating
// BEHAVIOUR
//  Reset: state=IDLE; every output 0, including the masks and both counters.
//  FSM states: IDLE, ARMED, DETECTED, HOLD (2-bit encoding); all outputs registered.
//  IDLE -> ARMED: enable & block sampled; stall_cycles <= 1.
//    If THRESHOLD==1, go directly to DETECTED instead.
//  ARMED:
//    block sampled high: stall_cycles+1.
//    When the incremented value == THRESHOLD -> DETECTED on that same edge; this edge also:
//      - captures both masks from the current-cycle inputs,
//      - sets rpt_valid=1 and deadlock_flag=1,
//      - increments deadlock_events.
//    block sampled low or enable low -> IDLE; stall_cycles <= 0.
//  DETECTED:
//    rpt_valid held high; masks frozen until handshake.
//    Handshake = rpt_valid & rpt_ready at an edge: rpt_valid <= 0, -> HOLD.
//    Report is never retracted. block falling, enable falling and clear do not affect rpt_valid.
//  HOLD: wait for block sampled low -> IDLE, stall_cycles <= 0. enable is ignored.
//  stall_cycles keeps incrementing while block=1 in DETECTED/HOLD; saturates at 2^CNT_W-1, never wraps.
//  deadlock_events saturates at 2^EVT_W-1.
//  Latency: first block-high sampling edge E0 -> rpt_valid high after edge E0+THRESHOLD-1.
//  clear: deadlock_flag <= 0 at the next edge.
//    If clear coincides with a detection edge, detection wins (flag stays 1).
//  Mask outputs are held after handshake and updated only at the next detection.
//  Reset mid-report drops the pending report (rpt_valid <= 0) with no handshake.
// STRUCTURE
//  Shared package sobel_hls_deadlock_pkg holds:
//    - FSM state encodings (ST_IDLE..ST_HOLD),
//    - default THRESHOLD/CNT_W/EVT_W,
//    - NUM_AXIS/NUM_INST for the sobel_inst instance.
//  Sub-module sobel_hls_sat_counter (param W; inputs inc, clr; output cnt), instantiated twice:
//    stall_cycles and deadlock_events.
//  FSM, snapshot registers and handshake logic live in the top.
// TESTING
//  T1 THRESHOLD=4, block high for 4 edges, axis=3'b010, idle=3'b101
//     -> rpt_valid=1 after 4th edge, masks 010/101, events=1, flag=1.
//  T2 block high 3 edges then low 1 edge then high 4 edges
//     -> no report after the first run; stall_cycles resets to 0; report after the 2nd run only.
//  T3 detection with rpt_ready=0 for 10 cycles, block and axis toggling meanwhile
//     -> rpt_valid and masks stable; handshake on ready; state=HOLD while block=1, IDLE after it drops.
//  T4 clear asserted on the detection edge -> flag=1; clear one cycle later -> flag=0, events unchanged.
//  T5 CNT_W=3, block held high 20 cycles -> stall_cycles saturates at 7; EVT_W=2 after 5 detections -> events=3.
//  T6 reset asserted while rpt_valid=1 -> all outputs 0 next edge; enable=0 with block=1 -> stays IDLE.

Source files
------------

// File: rtl/sobel_hls_deadlock_pkg.sv
// Shared definitions for the sobel deadlock reporter: FSM encodings and default sizing.
package sobel_hls_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_DETECTED = 2'd2,
    ST_HOLD     = 2'd3
  } state_e;

  localparam int DEF_THRESHOLD  = 1024;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_EVT_W      = 8;
  localparam int SOBEL_NUM_AXIS = 3;
  localparam int SOBEL_NUM_INST = 3;

endpackage

// File: rtl/sobel_hls_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sobel_hls_sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sobel_hls_deadlock_reporter.sv
// Qualifies the monitor's block signal for persistence, snapshots the stall signature and
// delivers it once over a valid/ready port; keeps a sticky flag and a saturating event count.
module sobel_hls_deadlock_reporter
  import sobel_hls_deadlock_pkg::*;
#(
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int EVT_W     = DEF_EVT_W,
  parameter int NUM_AXIS  = SOBEL_NUM_AXIS,
  parameter int NUM_INST  = SOBEL_NUM_INST
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                block,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic                clear,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [NUM_AXIS-1:0] rpt_axis_mask,
  output logic [NUM_INST-1:0] rpt_idle_mask,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic                deadlock_flag,
  output logic [EVT_W-1:0]    deadlock_events
);

  state_e              state_q, state_d;
  logic                rpt_valid_q, rpt_valid_d;
  logic                flag_q, flag_d;
  logic [NUM_AXIS-1:0] axis_q, axis_d;
  logic [NUM_INST-1:0] idle_q, idle_d;
  logic                detect, stall_inc, stall_clr, handshake;
  logic [CNT_W:0]      stall_nxt;

  // One extra bit so the threshold compare cannot alias on a full counter.
  assign stall_nxt = {1'b0, stall_cycles} + (CNT_W + 1)'(1);
  assign handshake = rpt_valid_q & rpt_ready;

  always_comb begin
    state_d   = state_q;
    detect    = 1'b0;
    stall_inc = 1'b0;
    stall_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && block) begin
          stall_inc = 1'b1;
          if (THRESHOLD == 1) begin
            detect  = 1'b1;
            state_d = ST_DETECTED;
          end else begin
            state_d = ST_ARMED;
          end
        end else begin
          stall_clr = 1'b1;
        end
      end
      ST_ARMED: begin
        if (enable && block) begin
          stall_inc = 1'b1;
          if (stall_nxt == (CNT_W + 1)'(THRESHOLD)) begin
            detect  = 1'b1;
            state_d = ST_DETECTED;
          end
        end else begin
          stall_clr = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_DETECTED: begin
        stall_inc = block;
        stall_clr = ~block;
        if (handshake) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (block) begin
          stall_inc = 1'b1;
        end else begin
          stall_clr = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Report, flag and snapshot next-state; detection beats both handshake and clear.
  always_comb begin
    rpt_valid_d = rpt_valid_q;
    flag_d      = flag_q;
    axis_d      = axis_q;
    idle_d      = idle_q;
    if (handshake) rpt_valid_d = 1'b0;
    if (clear)     flag_d      = 1'b0;
    if (detect) begin
      rpt_valid_d = 1'b1;
      flag_d      = 1'b1;
      axis_d      = axis_block_sigs;
      idle_d      = inst_idle_sigs;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rpt_valid_q <= 1'b0;
      flag_q      <= 1'b0;
      axis_q      <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      rpt_valid_q <= rpt_valid_d;
      flag_q      <= flag_d;
      axis_q      <= axis_d;
      idle_q      <= idle_d;
    end
  end

  sobel_hls_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc),
    .clr   (stall_clr),
    .cnt   (stall_cycles)
  );

  sobel_hls_sat_counter #(.W(EVT_W)) u_event_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (detect),
    .clr   (1'b0),
    .cnt   (deadlock_events)
  );

  assign rpt_valid     = rpt_valid_q;
  assign deadlock_flag = flag_q;
  assign rpt_axis_mask = axis_q;
  assign rpt_idle_mask = idle_q;

endmodule

// File: tb/tb_sobel_hls_deadlock_reporter.sv
// Bench for sobel_hls_deadlock_reporter: three instances (THRESHOLD 4/2/1) share stimulus and
// are compared against a per-instance behavioural model of the reporting rules.
module tb_sobel_hls_deadlock_reporter;

  logic       clock, reset, enable, block, clear, rpt_ready;
  logic [2:0] axis, idle;

  logic       rv_u0, rv_u1, rv_u2, fl_u0, fl_u1, fl_u2;
  logic [2:0] ax_u0, ax_u1, ax_u2, id_u0, id_u1, id_u2;
  logic [15:0] sc_u0;
  logic [2:0]  sc_u1;
  logic [3:0]  sc_u2;
  logic [7:0]  ev_u0, ev_u2;
  logic [1:0]  ev_u1;

  logic        rv[3], fl[3];
  logic [2:0]  ax[3], id[3];
  logic [15:0] sc[3];
  logic [7:0]  ev[3];

  assign rv[0] = rv_u0; assign rv[1] = rv_u1; assign rv[2] = rv_u2;
  assign fl[0] = fl_u0; assign fl[1] = fl_u1; assign fl[2] = fl_u2;
  assign ax[0] = ax_u0; assign ax[1] = ax_u1; assign ax[2] = ax_u2;
  assign id[0] = id_u0; assign id[1] = id_u1; assign id[2] = id_u2;
  assign sc[0] = sc_u0; assign sc[1] = 16'(sc_u1); assign sc[2] = 16'(sc_u2);
  assign ev[0] = ev_u0; assign ev[1] = 8'(ev_u1); assign ev[2] = ev_u2;

  sobel_hls_deadlock_reporter #(.THRESHOLD(4), .CNT_W(16), .EVT_W(8), .NUM_AXIS(3), .NUM_INST(3)) u0 (
    .clock(clock), .reset(reset), .enable(enable), .block(block), .axis_block_sigs(axis),
    .inst_idle_sigs(idle), .clear(clear), .rpt_valid(rv_u0), .rpt_ready(rpt_ready),
    .rpt_axis_mask(ax_u0), .rpt_idle_mask(id_u0), .stall_cycles(sc_u0),
    .deadlock_flag(fl_u0), .deadlock_events(ev_u0));

  sobel_hls_deadlock_reporter #(.THRESHOLD(2), .CNT_W(3), .EVT_W(2), .NUM_AXIS(3), .NUM_INST(3)) u1 (
    .clock(clock), .reset(reset), .enable(enable), .block(block), .axis_block_sigs(axis),
    .inst_idle_sigs(idle), .clear(clear), .rpt_valid(rv_u1), .rpt_ready(rpt_ready),
    .rpt_axis_mask(ax_u1), .rpt_idle_mask(id_u1), .stall_cycles(sc_u1),
    .deadlock_flag(fl_u1), .deadlock_events(ev_u1));

  sobel_hls_deadlock_reporter #(.THRESHOLD(1), .CNT_W(4), .EVT_W(8), .NUM_AXIS(3), .NUM_INST(3)) u2 (
    .clock(clock), .reset(reset), .enable(enable), .block(block), .axis_block_sigs(axis),
    .inst_idle_sigs(idle), .clear(clear), .rpt_valid(rv_u2), .rpt_ready(rpt_ready),
    .rpt_axis_mask(ax_u2), .rpt_idle_mask(id_u2), .stall_cycles(sc_u2),
    .deadlock_flag(fl_u2), .deadlock_events(ev_u2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Model: phase 0 = searching for a run, 1 = report pending, 2 = reported, waiting for block to drop.
  int         TH[3]   = '{4, 2, 1};
  int         CMAX[3] = '{65535, 7, 15};
  int         EMAX[3] = '{255, 3, 255};
  int         m_phase[3] = '{0, 0, 0};
  int         m_stall[3] = '{0, 0, 0};
  int         m_ev[3]    = '{0, 0, 0};
  bit         m_rv[3]    = '{0, 0, 0};
  bit         m_flag[3]  = '{0, 0, 0};
  logic [2:0] m_axis[3]  = '{3'd0, 3'd0, 3'd0};
  logic [2:0] m_idle[3]  = '{3'd0, 3'd0, 3'd0};

  task automatic model_step(input int i);
    bit hs, det;
    if (reset) begin
      m_phase[i] = 0; m_stall[i] = 0; m_ev[i] = 0; m_rv[i] = 0; m_flag[i] = 0;
      m_axis[i] = '0; m_idle[i] = '0;
      return;
    end
    hs  = m_rv[i] && rpt_ready;
    det = 0;
    case (m_phase[i])
      0: begin
        if (enable && block) begin
          m_stall[i] = m_stall[i] + 1;
          if (m_stall[i] == TH[i]) det = 1;
        end else begin
          m_stall[i] = 0;
        end
      end
      1: begin
        m_stall[i] = block ? ((m_stall[i] < CMAX[i]) ? m_stall[i] + 1 : CMAX[i]) : 0;
        if (hs) begin m_rv[i] = 0; m_phase[i] = 2; end
      end
      default: begin
        if (block) m_stall[i] = (m_stall[i] < CMAX[i]) ? m_stall[i] + 1 : CMAX[i];
        else begin m_stall[i] = 0; m_phase[i] = 0; end
      end
    endcase
    m_flag[i] = det ? 1'b1 : (clear ? 1'b0 : m_flag[i]);
    if (det) begin
      m_phase[i] = 1;
      m_rv[i]    = 1;
      m_axis[i]  = axis;
      m_idle[i]  = idle;
      m_ev[i]    = (m_ev[i] < EMAX[i]) ? m_ev[i] + 1 : EMAX[i];
    end
  endtask

  task automatic tick();
    @(posedge clock);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; block = 0; clear = 0; rpt_ready = 0; axis = '0; idle = '0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk_cnt++;
      if ({rv[i], fl[i], ev[i], sc[i], ax[i], id[i]} !== 32'd0)
        $display("FAIL reset_state inst%0d got=%h exp=0", i, {rv[i], fl[i], ev[i], sc[i], ax[i], id[i]});
      else pass_cnt++;
    end
    reset = 0;
  endtask

  task automatic test_detect();
    enable = 1; block = 1; axis = 3'b010; idle = 3'b101;
    repeat (3) tick();
    chk_cnt++;
    if (rv_u0 !== 1'b0 || sc_u0 !== 16'd3) $display("FAIL t1_pre valid=%0b stall=%0d exp 0/3", rv_u0, sc_u0);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({rv_u0, fl_u0, ev_u0, sc_u0, ax_u0, id_u0} !== {1'b1, 1'b1, 8'd1, 16'd4, 3'b010, 3'b101})
      $display("FAIL t1_detect got v=%0b f=%0b e=%0d s=%0d ax=%b id=%b exp 1/1/1/4/010/101",
               rv_u0, fl_u0, ev_u0, sc_u0, ax_u0, id_u0);
    else pass_cnt++;
    axis = 3'b000; idle = 3'b000; rpt_ready = 1;
    tick();
    chk_cnt++;
    if (rv_u0 !== 1'b0 || ax_u0 !== 3'b010 || id_u0 !== 3'b101)
      $display("FAIL t1_handshake valid=%0b ax=%b id=%b exp 0/010/101", rv_u0, ax_u0, id_u0);
    else pass_cnt++;
    rpt_ready = 0; block = 0;
    tick();
    chk_cnt++;
    if (sc_u0 !== 16'd0) $display("FAIL t1_release stall=%0d exp 0", sc_u0);
    else pass_cnt++;
  endtask

  task automatic test_interrupted();
    block = 1;
    repeat (3) tick();
    block = 0;
    tick();
    chk_cnt++;
    if (rv_u0 !== 1'b0 || sc_u0 !== 16'd0) $display("FAIL t2_break valid=%0b stall=%0d exp 0/0", rv_u0, sc_u0);
    else pass_cnt++;
    block = 1;
    repeat (3) tick();
    chk_cnt++;
    if (rv_u0 !== 1'b0 || sc_u0 !== 16'd3) $display("FAIL t2_run2_pre valid=%0b stall=%0d exp 0/3", rv_u0, sc_u0);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (rv_u0 !== 1'b1 || ev_u0 !== 8'd2) $display("FAIL t2_run2 valid=%0b events=%0d exp 1/2", rv_u0, ev_u0);
    else pass_cnt++;
    rpt_ready = 1; block = 0;
    tick(); tick();
    rpt_ready = 0;
  endtask

  task automatic test_hold();
    int s_hs;
    block = 1; enable = 1; axis = 3'b110; idle = 3'b011;
    repeat (4) tick();
    chk_cnt++;
    if (rv_u0 !== 1'b1 || ax_u0 !== 3'b110 || id_u0 !== 3'b011 || ev_u0 !== 8'd3)
      $display("FAIL t3_detect v=%0b ax=%b id=%b e=%0d exp 1/110/011/3", rv_u0, ax_u0, id_u0, ev_u0);
    else pass_cnt++;
    for (int k = 0; k < 10; k++) begin
      block = 1'($urandom); axis = 3'($urandom); idle = 3'($urandom); rpt_ready = 0;
      tick();
      chk_cnt++;
      if (rv_u0 !== 1'b1 || ax_u0 !== 3'b110 || id_u0 !== 3'b011)
        $display("FAIL t3_stable cyc%0d v=%0b ax=%b id=%b exp 1/110/011", k, rv_u0, ax_u0, id_u0);
      else pass_cnt++;
    end
    block = 1; rpt_ready = 1;
    tick();
    s_hs = m_stall[0];
    chk_cnt++;
    if (rv_u0 !== 1'b0 || ax_u0 !== 3'b110 || sc_u0 !== 16'(s_hs))
      $display("FAIL t3_handshake v=%0b ax=%b stall=%0d exp 0/110/%0d", rv_u0, ax_u0, sc_u0, s_hs);
    else pass_cnt++;
    rpt_ready = 0; enable = 0;
    repeat (3) tick();
    chk_cnt++;
    if (sc_u0 !== 16'(s_hs + 3) || ev_u0 !== 8'd3 || rv_u0 !== 1'b0)
      $display("FAIL t3_hold stall=%0d ev=%0d v=%0b exp %0d/3/0", sc_u0, ev_u0, rv_u0, s_hs + 3);
    else pass_cnt++;
    block = 0; enable = 1;
    tick();
    chk_cnt++;
    if (sc_u0 !== 16'd0) $display("FAIL t3_exit stall=%0d exp 0", sc_u0);
    else pass_cnt++;
    block = 1;
    repeat (4) tick();
    chk_cnt++;
    if (rv_u0 !== 1'b1 || ev_u0 !== 8'd4) $display("FAIL t3_rearm v=%0b ev=%0d exp 1/4", rv_u0, ev_u0);
    else pass_cnt++;
    rpt_ready = 1; block = 0;
    tick(); tick();
    rpt_ready = 0;
  endtask

  task automatic test_clear();
    clear = 1; block = 0;
    tick();
    chk_cnt++;
    if (fl_u0 !== 1'b0) $display("FAIL t4_clear_idle flag=%0b exp 0", fl_u0);
    else pass_cnt++;
    clear = 0; block = 1;
    repeat (3) tick();
    clear = 1;
    tick();
    chk_cnt++;
    if (fl_u0 !== 1'b1 || rv_u0 !== 1'b1 || ev_u0 !== 8'd5)
      $display("FAIL t4_clear_on_detect flag=%0b v=%0b ev=%0d exp 1/1/5", fl_u0, rv_u0, ev_u0);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (fl_u0 !== 1'b0 || rv_u0 !== 1'b1 || ev_u0 !== 8'd5)
      $display("FAIL t4_clear_after flag=%0b v=%0b ev=%0d exp 0/1/5", fl_u0, rv_u0, ev_u0);
    else pass_cnt++;
    clear = 0; rpt_ready = 1; block = 0;
    tick(); tick();
    rpt_ready = 0;
  endtask

  task automatic test_reset_mid();
    block = 1; enable = 1; axis = 3'b111; idle = 3'b111;
    repeat (4) tick();
    chk_cnt++;
    if (rv_u0 !== 1'b1) $display("FAIL t6_pending v=%0b exp 1", rv_u0);
    else pass_cnt++;
    reset = 1;
    tick();
    chk_cnt++;
    if ({rv_u0, fl_u0, ev_u0, sc_u0, ax_u0, id_u0} !== 32'd0)
      $display("FAIL t6_reset got=%h exp=0", {rv_u0, fl_u0, ev_u0, sc_u0, ax_u0, id_u0});
    else pass_cnt++;
    reset = 0; enable = 0; block = 1;
    repeat (6) tick();
    chk_cnt++;
    if (rv_u0 !== 1'b0 || sc_u0 !== 16'd0 || rv_u2 !== 1'b0 || sc_u2 !== 4'd0 || ev_u2 !== 8'd0)
      $display("FAIL t6_disabled v0=%0b s0=%0d v2=%0b s2=%0d e2=%0d exp all 0", rv_u0, sc_u0, rv_u2, sc_u2, ev_u2);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    reset = 1; block = 0;
    tick();
    reset = 0; enable = 1; block = 1; rpt_ready = 1;
    repeat (20) tick();
    chk_cnt++;
    if (sc_u1 !== 3'd7 || sc_u2 !== 4'd15 || ev_u1 !== 2'd1)
      $display("FAIL t5_stall_sat s1=%0d s2=%0d e1=%0d exp 7/15/1", sc_u1, sc_u2, ev_u1);
    else pass_cnt++;
    repeat (4) begin
      block = 0; tick();
      block = 1; tick(); tick(); tick();
    end
    chk_cnt++;
    if (ev_u1 !== 2'd3 || ev_u2 !== 8'd5)
      $display("FAIL t5_event_sat e1=%0d e2=%0d exp 3/5", ev_u1, ev_u2);
    else pass_cnt++;
    rpt_ready = 0; block = 0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] act, exp;
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      enable    = ($urandom_range(0, 15) != 0);
      block     = ($urandom_range(0, 7) != 0);
      clear     = ($urandom_range(0, 9) == 0);
      rpt_ready = ($urandom_range(0, 2) == 0);
      axis      = 3'($urandom);
      idle      = 3'($urandom);
      tick();
      for (int i = 0; i < 3; i++) begin
        act = {rv[i], fl[i], ev[i], sc[i], ax[i], id[i]};
        exp = {m_rv[i], m_flag[i], 8'(m_ev[i]), 16'(m_stall[i]), m_axis[i], m_idle[i]};
        chk_cnt++;
        if (act !== exp) $display("FAIL random cyc%0d inst%0d got=%h exp=%h", c, i, act, exp);
        else pass_cnt++;
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_detect();
    test_interrupted();
    test_hold();
    test_clear();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
